// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs field-level instruction bundles into 32-bit MIPS
// words and writes them sequentially into instruction memory from address 0.
// Optional build macro LOADER_CHECKSUM_EN adds a running XOR of written words.
//
// state  | meaning
// IDLE   | waiting for Start
// ACCEPT | InReady high, waiting for a bundle handshake
// WRITE  | one-cycle memory write strobe for the latched word
// DONE   | one-cycle Done pulse, then back to IDLE
module instr_encode_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [1:0]            InClass,
  input  logic [4:0]            InRs,
  input  logic [4:0]            InRt,
  input  logic [4:0]            InRd,
  input  logic [5:0]            InFunct,
  input  logic [15:0]           InImm,
  input  logic                  InLast,
  output logic                  MemWrEn,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [31:0]           MemWrData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [ADDR_WIDTH:0]   Count,
  output logic [31:0]           Checksum
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;

  function automatic logic [31:0] encode(input logic [1:0] cls, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [5:0] funct, input logic [15:0] imm);
    logic [31:0] w;
    case (cls)
      2'b00:   w = {6'b000000, rs, rt, rd, 5'b00000, funct};
      2'b01:   w = {6'b100011, rs, rt, imm};
      2'b10:   w = {6'b101011, rs, rt, imm};
      default: w = {6'b000100, rs, rt, imm};
    endcase
    return w;
  endfunction

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Next-state and datapath updates; Count doubles as the next free address
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_ACCEPT;
          addr_d  = '0;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (InValid) begin
          data_d  = encode(InClass, InRs, InRt, InRd, InFunct, InImm);
          last_d  = InLast;
          addr_d  = count_q[ADDR_WIDTH-1:0];
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (last_q) begin
          state_d = S_DONE;
        end else if (addr_q == {ADDR_WIDTH{1'b1}}) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign InReady   = (state_q == S_ACCEPT);
  assign MemWrEn   = (state_q == S_WRITE);
  assign Busy      = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign Done      = (state_q == S_DONE);
  assign MemAddr   = addr_q;
  assign MemWrData = data_q;
  assign Count     = count_q;
  assign Error     = error_q;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;

  // Running XOR of every word written this session
  always_comb begin
    chk_d = chk_q;
    if (state_q == S_IDLE && Start) chk_d = '0;
    else if (state_q == S_WRITE)    chk_d = chk_q ^ data_q;
  end

  // Checksum register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign Checksum = chk_q;
`else
  assign Checksum = 32'h0;
`endif

endmodule
